// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN_DEF = 32;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [0:0] BUS_IDLE = 1'b0;
  localparam logic [0:0] BUS_ACK  = 1'b1;

  // x0 and addresses beyond the implemented registers are never stored
  function automatic logic reg_valid(input logic [REG_AW-1:0] addr, input int unsigned nreg);
    return (addr != '0) && (32'(addr) < nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency results; set beats clear on the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_all_i,
  input  logic                  set_i,
  input  logic [REG_AW-1:0]     set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_AW-1:0]     clr_addr_i,
  input  logic [NRD*REG_AW-1:0] rd_addr_i,
  output logic [NRD-1:0]        rd_busy_o
);

  localparam int unsigned IW = $clog2(NREG);

  logic [NREG-1:0] busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (clr_all_i) begin
      busy_q <= '0;
    end else begin
      if (clr_i && reg_valid(clr_addr_i, NREG))
        busy_q[clr_addr_i[IW-1:0]] <= 1'b0;
      if (set_i && reg_valid(set_addr_i, NREG))
        busy_q[set_addr_i[IW-1:0]] <= 1'b1;
    end
  end

  always_comb begin
    logic [REG_AW-1:0] a;
    rd_busy_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = rd_addr_i[k*REG_AW +: REG_AW];
      if (reg_valid(a, NREG))
        rd_busy_o[k] = busy_q[a[IW-1:0]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with init sweep, busy scoreboard and debug bus port.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  output logic                  ready_o,
  input  logic [NRD*REG_AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0]   rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  we0_i,
  input  logic [REG_AW-1:0]     waddr0_i,
  input  logic [XLEN-1:0]       wdata0_i,
  input  logic                  we1_i,
  input  logic [REG_AW-1:0]     waddr1_i,
  input  logic [XLEN-1:0]       wdata1_i,
  input  logic                  sb_set_i,
  input  logic [REG_AW-1:0]     sb_addr_i,
  input  logic                  bus_req_i,
  input  logic                  bus_we_i,
  input  logic [REG_AW-1:0]     bus_addr_i,
  input  logic [XLEN-1:0]       bus_wdata_i,
  output logic                  bus_ack_o,
  output logic [XLEN-1:0]       bus_rdata_o
);

  localparam int unsigned IW = $clog2(NREG);

  logic [XLEN-1:0]   mem [NREG];
  logic [0:0]        state_q;
  logic [0:0]        bus_st_q;
  logic [REG_AW-1:0] idx_q;
  logic              ready_q;
  logic [XLEN-1:0]   bus_rdata_q;

  logic run, w0_act, w1_act, bus_acc, bus_ok, init_last;

  assign run       = (state_q == ST_RUN);
  assign w0_act    = run && we0_i && reg_valid(waddr0_i, NREG);
  assign w1_act    = run && we1_i && reg_valid(waddr1_i, NREG);
  assign bus_ok    = reg_valid(bus_addr_i, NREG);
  assign bus_acc   = run && !clr_i && bus_req_i && !we0_i && !we1_i && (bus_st_q == BUS_IDLE);
  assign init_last = (32'(idx_q) == NREG - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      idx_q       <= REG_AW'(1);
      ready_q     <= 1'b0;
      bus_st_q    <= BUS_IDLE;
      bus_rdata_q <= '0;
    end else begin
      ready_q <= run;
      if (state_q == ST_INIT) begin
        idx_q <= idx_q + REG_AW'(1);
        if (init_last) state_q <= ST_RUN;
      end else if (clr_i) begin
        state_q <= ST_INIT;
        idx_q   <= REG_AW'(1);
      end
      bus_st_q <= bus_acc ? BUS_ACK : BUS_IDLE;
      if (bus_acc && !bus_we_i)
        bus_rdata_q <= bus_ok ? mem[bus_addr_i[IW-1:0]] : '0;
    end
  end

  // No reset on the array so it can map to RAM; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[idx_q[IW-1:0]] <= '0;
    end else begin
      if (w1_act) mem[waddr1_i[IW-1:0]] <= wdata1_i;
      if (w0_act) mem[waddr0_i[IW-1:0]] <= wdata0_i;
      if (bus_acc && bus_we_i && bus_ok) mem[bus_addr_i[IW-1:0]] <= bus_wdata_i;
    end
  end

  always_comb begin
    logic [REG_AW-1:0] a;
    rd_data_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = rd_addr_i[k*REG_AW +: REG_AW];
      if (reg_valid(a, NREG)) begin
`ifdef REGFILE_BYPASS_EN
        if (w0_act && (waddr0_i == a))
          rd_data_o[k*XLEN +: XLEN] = wdata0_i;
        else if (w1_act && (waddr1_i == a))
          rd_data_o[k*XLEN +: XLEN] = wdata1_i;
        else
          rd_data_o[k*XLEN +: XLEN] = mem[a[IW-1:0]];
`else
        rd_data_o[k*XLEN +: XLEN] = mem[a[IW-1:0]];
`endif
      end
    end
  end

  regfile_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_all_i  (run && clr_i),
    .set_i      (run && sb_set_i),
    .set_addr_i (sb_addr_i),
    .clr_i      (run && we1_i),
    .clr_addr_i (waddr1_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o)
  );

  assign ready_o     = ready_q;
  assign bus_ack_o   = (bus_st_q == BUS_ACK);
  assign bus_rdata_o = bus_rdata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: NREG=32 instance for main tests, NREG=16 instance for size/clear tests.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr, ready, we0, we1, sb_set, bus_req, bus_we, bus_ack;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [4:0]  waddr0, waddr1, sb_addr, bus_addr;
  logic [31:0] wdata0, wdata1, bus_wdata, bus_rdata;

  logic        s_clr, s_ready, s_we0, s_sb_set, s_ack;
  logic [9:0]  s_rd_addr;
  logic [63:0] s_rd_data;
  logic [1:0]  s_rd_busy;
  logic [4:0]  s_waddr0, s_sb_addr;
  logic [31:0] s_wdata0, s_rdata;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .ready_o(ready),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr),
    .bus_req_i(bus_req), .bus_we_i(bus_we), .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata),
    .bus_ack_o(bus_ack), .bus_rdata_o(bus_rdata)
  );

  regfile_mp #(.XLEN(32), .NREG(16), .NRD(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr_i(s_clr), .ready_o(s_ready),
    .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_busy_o(s_rd_busy),
    .we0_i(s_we0), .waddr0_i(s_waddr0), .wdata0_i(s_wdata0),
    .we1_i(1'b0), .waddr1_i(5'd0), .wdata1_i(32'd0),
    .sb_set_i(s_sb_set), .sb_addr_i(s_sb_addr),
    .bus_req_i(1'b0), .bus_we_i(1'b0), .bus_addr_i(5'd0), .bus_wdata_i(32'd0),
    .bus_ack_o(s_ack), .bus_rdata_o(s_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    lat = 0;
    rd  = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus_ack) break;
    end
    if (!bus_ack) check("bus_timeout", 64'd0, 64'd1);
    rd = bus_rdata;
    bus_req = 1'b0; bus_we = 1'b0;
    tick();
  endtask

  int          lat, low_cnt;
  logic [31:0] rdv;

  initial begin
    clr = 0; we0 = 0; we1 = 0; sb_set = 0; bus_req = 0; bus_we = 0;
    rd_addr = '0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    sb_addr = '0; bus_addr = '0; bus_wdata = '0;
    s_clr = 0; s_we0 = 0; s_sb_set = 0; s_rd_addr = '0; s_waddr0 = '0; s_wdata0 = '0; s_sb_addr = '0;

    #1;
    check("rst_ready", ready, 0);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_busy", rd_busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Sweep timing for both sizes; a core write in the last INIT cycle must be dropped
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 30) begin we0 = 1; waddr0 = 5'd3; wdata0 = 32'h77; end
      if (i == 31) begin we0 = 0; check("ready_31", ready, 0); end
      if (i == 32) check("ready_32", ready, 1);
      if (i == 15) check("ready16_15", s_ready, 0);
      if (i == 16) check("ready16_16", s_ready, 1);
    end

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd0, 5'(a)};
      #1;
      check($sformatf("init_x%0d", a), rd_data[31:0], 0);
    end

    // W0 beats W1 on the same register
    we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
    we1 = 1; waddr1 = 5; wdata1 = 32'hBEEF;
    tick();
    we0 = 0; we1 = 0;
    rd_addr = {5'd0, 5'd5}; #1;
    check("w0_wins_x5", rd_data[31:0], 32'h1234);

    we0 = 1; waddr0 = 0; wdata0 = 32'hFF;
    tick();
    we0 = 0;
    rd_addr = {5'd0, 5'd0}; #1;
    check("x0_zero", rd_data[31:0], 0);

    // Scoreboard set, later cleared by the late write port
    rd_addr = {5'd7, 5'd7}; #1;
    check("busy7_pre", rd_busy[1], 0);
    sb_set = 1; sb_addr = 7;
    tick();
    sb_set = 0;
    check("busy7_c1", rd_busy[1], 1);
    tick(); check("busy7_c2", rd_busy[1], 1);
    tick(); check("busy7_c3", rd_busy[1], 1);
    we1 = 1; waddr1 = 7; wdata1 = 32'hA5;
    tick();
    we1 = 0;
    check("busy7_clr", rd_busy[1], 0);
    check("x7_data", rd_data[31:0], 32'hA5);
    sb_set = 1; sb_addr = 7; we1 = 1; waddr1 = 7; wdata1 = 32'h5A;
    tick();
    sb_set = 0; we1 = 0;
    check("busy7_setwins", rd_busy[1], 1);
    check("x7_data2", rd_data[31:0], 32'h5A);
    sb_set = 1; sb_addr = 0;
    tick();
    sb_set = 0;
    rd_addr = {5'd0, 5'd0}; #1;
    check("busy_x0", rd_busy[0], 0);

    // Bus read starved by two core-write cycles
    bus_req = 1; bus_we = 0; bus_addr = 5;
    we0 = 1; waddr0 = 6; wdata0 = 32'h66;
    tick(); check("bus_blk1_ack", bus_ack, 0);
    tick(); we0 = 0; check("bus_blk2_ack", bus_ack, 0);
    tick(); check("bus_blk3_ack", bus_ack, 1);
    check("bus_rd_x5", bus_rdata, 32'h1234);
    bus_req = 0;
    tick(); check("bus_ack_1cyc", bus_ack, 0);
    rd_addr = {5'd0, 5'd6}; #1;
    check("x6_data", rd_data[31:0], 32'h66);

    bus_xfer(1'b1, 5'd8, 32'hCAFE, lat, rdv);
    check("bus_wr_lat", 64'(lat), 1);
    rd_addr = {5'd0, 5'd8}; #1;
    check("bus_wr_x8", rd_data[31:0], 32'hCAFE);
    bus_xfer(1'b1, 5'd0, 32'hDEAD, lat, rdv);
    bus_xfer(1'b0, 5'd0, 32'h0, lat, rdv);
    check("bus_rd_x0", rdv, 0);
    bus_xfer(1'b0, 5'd8, 32'h0, lat, rdv);
    check("bus_rd_x8", rdv, 32'hCAFE);

    // Same-cycle write/read on x9 (stored value 0)
    rd_addr = {5'd0, 5'd9};
    we0 = 1; waddr0 = 9; wdata0 = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
    check("x9_same_cycle", rd_data[31:0], 32'h55);
`else
    check("x9_same_cycle", rd_data[31:0], 32'h0);
`endif
    tick();
    we0 = 0; #1;
    check("x9_next_cycle", rd_data[31:0], 32'h55);

    // NREG=16: out-of-range write must not alias onto x4
    s_we0 = 1; s_waddr0 = 20; s_wdata0 = 32'hDD;
    tick();
    s_waddr0 = 5; s_wdata0 = 32'h99;
    tick();
    s_we0 = 0;
    s_rd_addr = {5'd4, 5'd20}; #1;
    check("n16_x20", s_rd_data[31:0], 0);
    check("n16_x4", s_rd_data[63:32], 0);
    s_rd_addr = {5'd3, 5'd5}; #1;
    check("n16_x5", s_rd_data[31:0], 32'h99);
    s_sb_set = 1; s_sb_addr = 3;
    tick();
    s_sb_set = 0;
    check("n16_busy3", s_rd_busy[1], 1);

    s_clr = 1;
    tick();
    s_clr = 0;
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_ready) break;
      low_cnt++;
    end
    check("n16_clr_low", 64'(low_cnt), 15);
    check("n16_clr_x5", s_rd_data[31:0], 0);
    check("n16_clr_busy", s_rd_busy[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
